board_link: RTL and testbench
=============================

Name: board_link

Overview:
- Parametrised token-passing half-duplex link between two FPGA boards, one per board.
- Exactly one board holds the token at a time and drives a DATA_W-bit shared bidirectional bus.
- The local "move committed" pulse hands the token to the peer.
- The receiving board captures the last bus value the peer drove and flags it with a one-cycle valid pulse.
- Adds over the previous link: configurable width, slot length and synchroniser depth; deterministic tie-break; release timeout; sticky error flag.

Parameters:
- DATA_W, 2: shared bus width.
- SLOT_LEN, 7: clocks per decision slot (≥2).
- SYNC_STAGES, 2: synchroniser depth on tok_in and bus inputs (≥2).
- START_ACTIVE, 1: 1 = this board holds the token out of reset and wins conflicts. The two boards must use opposite values.
- TIMEOUT_SLOTS, 64: slots to wait in RELEASE before reclaiming the token.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tok_out  out  1  token-held line to peer
- tok_in  in  1  peer's tok_out (asynchronous)
- pass  in  1  one-cycle pulse: hand token to peer
- tx_data  in  DATA_W  local data driven while holding
- bus  inout  DATA_W  shared data lines
- rx_data  out  DATA_W  last data received from peer
- rx_valid  out  1  one-cycle pulse: rx_data updated
- active  out  1  this board holds the token
- link_err  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst. All flops reset asynchronously.
- Synchronisers: tok_in and bus pass through SYNC_STAGES flops, reset 0. Internal names: tok_s, bus_s.
- Slot counter:
  - cnt counts 0..SLOT_LEN-1 and wraps; reset 0.
  - slot_tick = (cnt==0).
  - State changes only on slot_tick, except pass latching.
- States: HOLD, RELEASE, WAIT.
  - Reset state is HOLD if START_ACTIVE else WAIT.
  - Reset values: pass_pend=0, tok_prev=0, timeout counter=0, rx_data=0, rx_valid=0, link_err=0.
- Outputs:
  - tok_out = active = (state==HOLD).
  - bus = tx_data when state==HOLD, otherwise high-Z. tx_data is not registered.
- pass_pend:
  - Set by pass while in HOLD.
  - pass in RELEASE or WAIT is ignored and not retained.
  - Cleared when consumed, and on any exit from HOLD.
- HOLD at slot_tick:
  - If tok_s==1 (conflict): set link_err. If START_ACTIVE==0, go to WAIT and clear pass_pend. If START_ACTIVE==1, stay in HOLD.
  - Else if pass_pend: go to RELEASE, clear the timeout counter.
- RELEASE at slot_tick:
  - tok_s==1: go to WAIT (peer took the token).
  - Else increment the timeout counter. When it reaches TIMEOUT_SLOTS: go back to HOLD and set link_err.
  - The bus is tri-stated for the whole of RELEASE (turnaround).
- WAIT at slot_tick:
  - While tok_s==1: shadow <= bus_s.
  - Falling edge (tok_prev==1 and tok_s==0): rx_data <= shadow, rx_valid=1 for exactly one cycle, go to HOLD.
  - tok_prev <= tok_s on every slot_tick.
  - tok_s low with tok_prev low: no action. This covers the initial state and prevents a false capture.
- Latency:
  - pass to tok_out falling: at most SLOT_LEN cycles.
  - Peer release to local HOLD: at most SYNC_STAGES + SLOT_LEN cycles.
- Other rules:
  - link_err clears only on reset.
  - pass and a conflict in the same tick: the conflict rule wins.
  - Reset mid-operation returns to the reset state regardless of current state; the bus is released or driven immediately per START_ACTIVE.

Decomposition:
- Package link_pkg: state enum typedef link_state_t {HOLD, RELEASE, WAIT}.
- Package link_pkg: localparam for the timeout counter width, $clog2(TIMEOUT_SLOTS+1).
- One sub-module, link_sync: parametrised width/depth synchroniser with async active-low reset, instantiated for tok_in (width 1) and bus (width DATA_W).

Test Plan (DATA_W=2, SLOT_LEN=7, SYNC_STAGES=2, TIMEOUT_SLOTS=8):
- Reset with START_ACTIVE=1, tx_data=2'b01 -> tok_out=1, active=1, bus=2'b01, rx_valid=0, link_err=0. Same with START_ACTIVE=0 -> tok_out=0, bus=Z.
- Two instances cross-connected on a shared bus (A start=1, B start=0); A tx_data=2'b10, pulse A.pass -> A.tok_out falls within 7 cycles; B.rx_data=2'b10 with a single-cycle rx_valid; B.active=1 within 9 cycles of A release; A returns to WAIT.
- pass pulsed while WAIT -> no state change; a later token arrival does not trigger an immediate release.
- tok_in tied 0, start=1, pass -> RELEASE for 8 slots, then HOLD with link_err=1 (56 ± 7 cycles after release).
- Conflict: start=0 instance in HOLD and tok_in forced 1 for one slot -> WAIT, link_err=1. Start=1 instance under the same stimulus -> stays HOLD, link_err=1.
- rst asserted during RELEASE on a start=1 instance -> immediately HOLD, bus driven, pass_pend=0, link_err=0.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and sizing helpers for the board-to-board token link.
package link_pkg;

  typedef enum logic [1:0] {HOLD, RELEASE, WAIT} link_state_t;

  // Timeout counter width for a given slot budget: $clog2(TIMEOUT_SLOTS+1).
  function automatic int to_w(input int timeout_slots);
    return $clog2(timeout_slots + 1);
  endfunction

endpackage

// File: rtl/link_sync.sv
// Multi-flop synchroniser for asynchronous inputs, async active-low reset to 0.
module link_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/board_link.sv
// Token-passing half-duplex link: the token holder drives the shared bus, the
// peer captures the last value driven when the token comes back to it.
module board_link
  import link_pkg::*;
#(
  parameter int DATA_W        = 2,
  parameter int SLOT_LEN      = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int START_ACTIVE  = 1,
  parameter int TIMEOUT_SLOTS = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              tok_out,
  input  logic              tok_in,
  input  logic              pass,
  input  logic [DATA_W-1:0] tx_data,
  inout  wire  [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              active,
  output logic              link_err
);

  localparam int CW = $clog2(SLOT_LEN);
  localparam int TW = to_w(TIMEOUT_SLOTS);
  localparam link_state_t RST_STATE = (START_ACTIVE != 0) ? HOLD : WAIT;

  link_state_t       state;
  logic [CW-1:0]     cnt;
  logic              slot_tick;
  logic              tok_s;
  logic [DATA_W-1:0] bus_s;
  logic [DATA_W-1:0] shadow;
  logic              pass_pend;
  logic              tok_prev;
  logic [TW-1:0]     to_cnt;

  link_sync #(.W(1), .STAGES(SYNC_STAGES)) u_tok_sync (
    .clk(clk), .rst(rst), .d(tok_in), .q(tok_s)
  );

  link_sync #(.W(DATA_W), .STAGES(SYNC_STAGES)) u_bus_sync (
    .clk(clk), .rst(rst), .d(bus), .q(bus_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          cnt <= '0;
    else if (cnt == CW'(SLOT_LEN - 1)) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  assign slot_tick = (cnt == '0);
  assign active    = (state == HOLD);
  assign tok_out   = active;
  assign bus       = active ? tx_data : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RST_STATE;
      pass_pend <= 1'b0;
      tok_prev  <= 1'b0;
      to_cnt    <= '0;
      shadow    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      link_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == HOLD && pass) pass_pend <= 1'b1;
      if (slot_tick) begin
        tok_prev <= tok_s;
        case (state)
          HOLD: begin
            if (tok_s) begin
              // Both sides claim the token; only the START_ACTIVE board keeps it.
              link_err <= 1'b1;
              if (START_ACTIVE == 0) begin
                state     <= WAIT;
                pass_pend <= 1'b0;
              end
            end else if (pass_pend || pass) begin
              state     <= RELEASE;
              pass_pend <= 1'b0;
              to_cnt    <= '0;
            end
          end
          RELEASE: begin
            if (tok_s) begin
              // Sample the peer's bus now too, in case it hands back within one slot.
              state  <= WAIT;
              shadow <= bus_s;
            end else if (to_cnt == TW'(TIMEOUT_SLOTS - 1)) begin
              state    <= HOLD;
              link_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          WAIT: begin
            if (tok_s) shadow <= bus_s;
            if (tok_prev && !tok_s) begin
              rx_data  <= shadow;
              rx_valid <= 1'b1;
              state    <= HOLD;
            end
          end
          default: state <= RST_STATE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_link.sv
// Bench: A/B cross-connected pair with randomized ping-pong, plus two
// stand-alone instances (C start=1, D start=0) driven directly.
module tb_board_link;

  localparam int DW = 2;
  localparam int SL = 7;
  localparam int SS = 2;
  localparam int TS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
  logic pass_a = 1'b0, pass_b = 1'b0, pass_c = 1'b0, pass_d = 1'b0;
  logic [DW-1:0] tx_a = 2'b01, tx_b = 2'b00, tx_c = 2'b10, tx_d = 2'b01;
  logic tok_c = 1'b0, tok_d = 1'b0;
  logic [DW-1:0] d_drv = '0;
  logic d_en = 1'b0;

  wire tok_a, tok_b, tok_out_c, tok_out_d;
  wire [DW-1:0] bus_ab, bus_c, bus_d;
  logic [DW-1:0] rxd_a, rxd_b, rxd_c, rxd_d;
  logic rxv_a, rxv_b, rxv_c, rxv_d;
  logic act_a, act_b, act_c, act_d;
  logic err_a, err_b, err_c, err_d;

  assign bus_d = d_en ? d_drv : 2'bzz;

  board_link #(.DATA_W(DW), .SLOT_LEN(SL), .SYNC_STAGES(SS), .START_ACTIVE(1), .TIMEOUT_SLOTS(TS)) u_a (
    .clk(clk), .rst(rst_ab), .tok_out(tok_a), .tok_in(tok_b), .pass(pass_a), .tx_data(tx_a),
    .bus(bus_ab), .rx_data(rxd_a), .rx_valid(rxv_a), .active(act_a), .link_err(err_a));
  board_link #(.DATA_W(DW), .SLOT_LEN(SL), .SYNC_STAGES(SS), .START_ACTIVE(0), .TIMEOUT_SLOTS(TS)) u_b (
    .clk(clk), .rst(rst_ab), .tok_out(tok_b), .tok_in(tok_a), .pass(pass_b), .tx_data(tx_b),
    .bus(bus_ab), .rx_data(rxd_b), .rx_valid(rxv_b), .active(act_b), .link_err(err_b));
  board_link #(.DATA_W(DW), .SLOT_LEN(SL), .SYNC_STAGES(SS), .START_ACTIVE(1), .TIMEOUT_SLOTS(TS)) u_c (
    .clk(clk), .rst(rst_c), .tok_out(tok_out_c), .tok_in(tok_c), .pass(pass_c), .tx_data(tx_c),
    .bus(bus_c), .rx_data(rxd_c), .rx_valid(rxv_c), .active(act_c), .link_err(err_c));
  board_link #(.DATA_W(DW), .SLOT_LEN(SL), .SYNC_STAGES(SS), .START_ACTIVE(0), .TIMEOUT_SLOTS(TS)) u_d (
    .clk(clk), .rst(rst_d), .tok_out(tok_out_d), .tok_in(tok_d), .pass(pass_d), .tx_data(tx_d),
    .bus(bus_d), .rx_data(rxd_d), .rx_valid(rxv_d), .active(act_d), .link_err(err_d));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
  endtask

  function automatic logic act(input int s);
    case (s)
      0: return act_a;
      1: return act_b;
      2: return act_c;
      default: return act_d;
    endcase
  endfunction

  function automatic logic rxv(input int s);
    return (s == 0) ? rxv_a : rxv_b;
  endfunction

  function automatic int rxd(input int s);
    return (s == 0) ? int'(rxd_a) : int'(rxd_b);
  endfunction

  task automatic set_pass(input int s, input logic v);
    case (s)
      0: pass_a = v;
      1: pass_b = v;
      2: pass_c = v;
      default: pass_d = v;
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pass pulse; returns edges until the holder drops the token.
  task automatic pulse_pass(input int s, output int lat);
    @(negedge clk); set_pass(s, 1'b1);
    @(negedge clk); set_pass(s, 1'b0);
    lat = 1;
    while (act(s) && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic wait_act(input int s, input logic v, input int max, output int n);
    n = 0;
    while (act(s) !== v && n < max) begin @(negedge clk); n++; end
  endtask

  // Reference model: token owner plus the ordered list of values handed over.
  int owner;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] exp_v;

  initial begin
    int lat, n, rcv;
    #2;
    rst_ab = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    #2;
    chk("rst_a_tok", int'(tok_a), 1);
    chk("rst_a_act", int'(act_a), 1);
    chk("rst_bus", int'(bus_ab), 1);
    chk("rst_b_tok", int'(tok_b), 0);
    chk("rst_b_act", int'(act_b), 0);
    chk("rst_rxv", int'({rxv_a, rxv_b, rxv_c, rxv_d}), 0);
    chk("rst_err", int'({err_a, err_b, err_c, err_d}), 0);
    chk("rst_cd_tok", int'({tok_out_c, tok_out_d}), 2);
    chk("rst_rxd", int'({rxd_c, rxd_d}), 0);
    @(negedge clk);
    rst_ab = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    tick(2 * SL);

    // Randomized ping-pong between A and B.
    owner = 0;
    tx_a  = 2'b10;
    for (int r = 0; r < 14; r++) begin
      rcv = 1 - owner;
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); set_pass(rcv, 1'b1);
        @(negedge clk); set_pass(rcv, 1'b0);
        tick(2);
        chk("ign_pass", int'(act(rcv)), 0);
      end
      tick($urandom_range(0, 10));
      sent_q.push_back(owner == 0 ? tx_a : tx_b);
      pulse_pass(owner, lat);
      chk("pass_lat", int'(lat <= SL && !act(owner)), 1);
      wait_act(rcv, 1'b1, 40, n);
      chk("acq_lat", int'(n <= SS + SL && act(rcv)), 1);
      exp_v = sent_q.pop_front();
      chk("rx_valid", int'(rxv(rcv)), 1);
      chk("rx_data", rxd(rcv), int'(exp_v));
      owner = rcv;
      if (owner == 0) tx_a = DW'($urandom); else tx_b = DW'($urandom);
      @(negedge clk);
      chk("rxv_pulse", int'(rxv(rcv)), 0);
      chk("old_wait", int'(act(1 - owner)), 0);
      chk("bus_drv", int'(bus_ab), owner == 0 ? int'(tx_a) : int'(tx_b));
      tick(2 * SL);
      chk("no_spur_rel", int'(act(owner)), 1);
    end
    chk("ab_err", int'({err_a, err_b}), 0);

    // C (start=1): conflict keeps the token.
    tok_c = 1'b1;
    tick(SL + SS + 1);
    chk("conf1_hold", int'(act_c), 1);
    chk("conf1_err", int'(err_c), 1);
    tok_c = 1'b0;
    tick(SL);
    rst_c = 1'b0; #1;
    chk("rst_err_clr", int'(err_c), 0);
    @(negedge clk); rst_c = 1'b1;
    tick(SL);

    // C: no peer answer, reclaim after TS slots.
    pulse_pass(2, lat);
    chk("to_rel", int'(lat <= SL && !act_c), 1);
    wait_act(2, 1'b1, 100, n);
    chk("to_lat", int'(n >= TS * SL - SL && n <= TS * SL + SL && act_c), 1);
    chk("to_err", int'(err_c), 1);

    // C: reset while in RELEASE.
    tick(SL);
    pulse_pass(2, lat);
    tick(3);
    chk("pre_rst_rel", int'(act_c), 0);
    rst_c = 1'b0; #1;
    chk("rst_rel_act", int'(act_c), 1);
    chk("rst_rel_bus", int'(bus_c), int'(tx_c));
    chk("rst_rel_err", int'(err_c), 0);
    @(negedge clk); rst_c = 1'b1;
    tick(3 * SL);
    chk("rst_no_pend", int'(act_c), 1);

    // D (start=0): receive from a bench-driven peer, then lose a conflict.
    d_drv = 2'b11; d_en = 1'b1; tok_d = 1'b1;
    tick(2 * SL);
    tok_d = 1'b0; d_en = 1'b0;
    wait_act(3, 1'b1, 40, n);
    chk("d_acq", int'(n <= SS + SL && act_d), 1);
    chk("d_rxv", int'(rxv_d), 1);
    chk("d_rxd", int'(rxd_d), 3);
    tok_d = 1'b1;
    tick(SL + SS + 1);
    chk("conf0_wait", int'(act_d), 0);
    chk("conf0_err", int'(err_d), 1);
    tok_d = 1'b0;
    tick(2 * SL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
